alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue/writeback sequencer that sits in front of the 16-bit `alu`. It is the producer of the ALU's opcode/funct/Ain/Bin and the consumer of its `out`.
- Accepts one instruction at a time over a valid/ready handshake and decodes the register and immediate fields.
- Reads operands from the register file and sequences the ALU through registered inputs.
- Returns the result with its destination register over a second valid/ready handshake.

Parameters:
- DATA_W, 16, datapath width. Instruction field positions are fixed for 16.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept an instruction
- instr  in  16  instruction word
- rs_addr  out  3  register-file read address A
- rt_addr  out  3  register-file read address B
- rs_data  in  DATA_W  register-file data A (combinational read)
- rt_data  in  DATA_W  register-file data B (combinational read)
- alu_opcode  out  5  to ALU opcode
- alu_funct  out  2  to ALU funct
- alu_Ain  out  DATA_W  to ALU Ain
- alu_Bin  out  DATA_W  to ALU Bin
- alu_out  in  DATA_W  from ALU out
- wb_valid  out  1  result available
- wb_ready  in  1  result consumer ready
- wb_reg  out  3  destination register
- wb_data  out  DATA_W  result

Behaviour:
- Reset (async, rst_n=0): state IDLE. All registered outputs are 0: alu_opcode, alu_funct, alu_Ain, alu_Bin, wb_valid, wb_reg, wb_data, rs_addr, rt_addr. in_ready is 1 once rst_n deasserts.
- Reset asserted in any state aborts the in-flight instruction; no writeback is issued.
- Legal opcodes:
  - I-arith: 01000 ADDI, 01001 SUBI, 01010 XORI, 01011 ANDNI.
  - I-shift: 10100 ROLI, 10101 SLLI, 10110 RORI, 10111 SRLI.
  - R-shift: 11010.
  - R-arith: 11011.
  - Anything else is illegal.
- Field extraction:
  - I-format: Rs=instr[10:8], Rd=instr[7:5], imm5=instr[4:0].
  - R-format: Rs=instr[10:8], Rt=instr[7:5], Rd=instr[4:2], funct=instr[1:0].
- Operand rules:
  - Ain = Rs data, always.
  - Bin for ADDI/SUBI = imm5 sign-extended to DATA_W.
  - Bin for XORI/ANDNI = imm5 zero-extended.
  - Bin for I-shifts = {0, imm5[3:0]}.
  - Bin for R-format = Rt data.
  - alu_funct = instr[1:0] for R-format, 2'b00 for I-format.
  - The ALU's operand order (SUB = Bin-Ain) is honoured by routing only; the block performs no arithmetic.
- FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture instr, go to OPER.
  - OPER: drive rs_addr/rt_addr from the captured instr. At the clock edge, register alu_opcode, alu_funct, alu_Ain, alu_Bin. Legal -> EXEC.
  - EXEC: ALU inputs held stable. At the clock edge, capture alu_out into wb_data and Rd into wb_reg. Go to WB.
  - WB: wb_valid=1. wb_reg and wb_data hold until wb_ready=1. On wb_valid&&wb_ready, go to IDLE.
- Latency: the accept edge is cycle 0; wb_valid asserts in cycle 3. Minimum issue interval is 4 cycles.
- in_ready=0 in OPER, EXEC and WB; no overlap between instructions.
- in_valid is ignored outside IDLE. instr need only be stable on the accept edge.
- wb_ready held high before WB: the handshake completes in the first WB cycle.
- wb_ready low: the block stalls in WB indefinitely with all outputs constant.
- ALU inputs keep their last values after EXEC; they are not cleared.
- Illegal opcode: consumed in OPER, no EXEC, no WB, return to IDLE. Exception: handling changes under the optional feature below.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_EN.
- Defined: adds output `illegal` (1 bit) and output `err_sticky` (1 bit).
  - `illegal` pulses high for exactly one cycle, the cycle after the illegal instruction is accepted (the OPER cycle).
  - `err_sticky` sets on that same cycle and is cleared only by rst_n.
  - Both are 0 after reset.
- Undefined: neither port exists. Illegal instructions are dropped silently as described under Behaviour.

Test Plan:
- ADDI: rs_data(R1)=2, instr=0x4165 -> rs_addr=1; alu_opcode=01000, alu_Ain=2, alu_Bin=5; wb_reg=3, wb_data=7; wb_valid asserts 3 cycles after accept.
- SUBI sign-extension: R1=2, instr=0x495F -> alu_Bin=0xFFFF; wb_reg=2, wb_data=0xFFFD. XORI zero-extension: R1=2, instr=0x515F -> alu_Bin=0x001F; wb_data=0x001D.
- R-arith ADD: R1=2, R2=3, instr=0xD950 -> rs_addr=1, rt_addr=2; alu_funct=00; wb_reg=4, wb_data=5.
- Backpressure: wb_ready=0 for 3 cycles in WB -> wb_valid=1, wb_data/wb_reg constant, in_ready=0; a second in_valid is not accepted until the cycle after the wb handshake.
- Illegal: instr=0x0800 -> no wb_valid; in_ready returns to 1 two cycles after accept. With ALU_ISSUE_ILLEGAL_EN: one-cycle `illegal` pulse, err_sticky=1 persists until reset.
- Reset in EXEC: rst_n=0 mid-instruction -> all outputs immediately 0, no wb_valid; a new ADDI issued afterwards completes normally.

Source files
------------

// File: rtl/alu_issue.sv
// Issue/writeback sequencer in front of the 16-bit ALU: accepts one instruction, reads operands,
// drives registered ALU inputs and returns the result. Optional macro: ALU_ISSUE_ILLEGAL_EN.
module alu_issue #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  output logic [2:0]        rs_addr,
  output logic [2:0]        rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [4:0]        alu_opcode,
  output logic [1:0]        alu_funct,
  output logic [DATA_W-1:0] alu_Ain,
  output logic [DATA_W-1:0] alu_Bin,
  input  logic [DATA_W-1:0] alu_out,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [2:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic              illegal,
  output logic              err_sticky
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OPER = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  logic [1:0]        state;
  logic [15:0]       instr_q;
  logic [4:0]        op_q;
  logic              is_r;
  logic              legal_q;
  logic [2:0]        rd;
  logic [DATA_W-1:0] bin_next;

  function automatic logic is_legal(input logic [4:0] op);
    return (op[4:2] == 3'b010) || (op[4:2] == 3'b101) || (op[4:1] == 4'b1101);
  endfunction

  // Register-file addresses come straight from the captured word, so they reset with it.
  assign rs_addr  = instr_q[10:8];
  assign rt_addr  = instr_q[7:5];
  assign op_q     = instr_q[15:11];
  assign is_r     = (op_q[4:1] == 4'b1101);
  assign legal_q  = is_legal(op_q);
  assign rd       = is_r ? instr_q[4:2] : instr_q[7:5];
  assign in_ready = rst_n && (state == IDLE);

  always_comb begin
    bin_next = rt_data;
    if (!is_r) begin
      if (op_q[4:1] == 4'b0100)
        bin_next = {{(DATA_W-5){instr_q[4]}}, instr_q[4:0]};
      else if (op_q[4:1] == 4'b0101)
        bin_next = {{(DATA_W-5){1'b0}}, instr_q[4:0]};
      else
        bin_next = {{(DATA_W-4){1'b0}}, instr_q[3:0]};
    end
  end

  // ALU inputs are only loaded for legal instructions and otherwise keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      instr_q    <= '0;
      alu_opcode <= '0;
      alu_funct  <= '0;
      alu_Ain    <= '0;
      alu_Bin    <= '0;
      wb_valid   <= 1'b0;
      wb_reg     <= '0;
      wb_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            instr_q <= instr;
            state   <= OPER;
          end
        end
        OPER: begin
          if (legal_q) begin
            alu_opcode <= op_q;
            alu_funct  <= is_r ? instr_q[1:0] : 2'b00;
            alu_Ain    <= rs_data;
            alu_Bin    <= bin_next;
            state      <= EXEC;
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          wb_data  <= alu_out;
          wb_reg   <= rd;
          wb_valid <= 1'b1;
          state    <= WB;
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  // Flagged on the accept edge so the pulse lines up with the OPER cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      illegal <= (state == IDLE) && in_valid && !is_legal(instr[15:11]);
      if ((state == IDLE) && in_valid && !is_legal(instr[15:11]))
        err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: table-driven vectors plus scoreboard of writebacks,
// with an ALU stub and register-file model on the bench side.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [2:0]  rs_addr, rt_addr;
  logic [15:0] rs_data, rt_data;
  logic [4:0]  alu_opcode;
  logic [1:0]  alu_funct;
  logic [15:0] alu_Ain, alu_Bin, alu_out;
  logic        wb_valid, wb_ready;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        illegal, err_sticky;
`endif

  alu_issue #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_Ain(alu_Ain), .alu_Bin(alu_Bin),
    .alu_out(alu_out), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg),
    .wb_data(wb_data)
`ifdef ALU_ISSUE_ILLEGAL_EN
    , .illegal(illegal), .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] regs [8];
  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  // ALU stub: SUB is Bin-Ain, ANDN is Ain & ~Bin, shifts use Bin[3:0].
  logic [3:0]  sh;
  logic [15:0] rol_v, ror_v;
  always_comb begin
    sh      = alu_Bin[3:0];
    rol_v   = (alu_Ain << sh) | (alu_Ain >> (5'd16 - {1'b0, sh}));
    ror_v   = (alu_Ain >> sh) | (alu_Ain << (5'd16 - {1'b0, sh}));
    alu_out = '0;
    case (alu_opcode)
      5'b01000: alu_out = alu_Ain + alu_Bin;
      5'b01001: alu_out = alu_Bin - alu_Ain;
      5'b01010: alu_out = alu_Ain ^ alu_Bin;
      5'b01011: alu_out = alu_Ain & ~alu_Bin;
      5'b10100: alu_out = rol_v;
      5'b10101: alu_out = alu_Ain << sh;
      5'b10110: alu_out = ror_v;
      5'b10111: alu_out = alu_Ain >> sh;
      5'b11011: begin
        case (alu_funct)
          2'b00:   alu_out = alu_Ain + alu_Bin;
          2'b01:   alu_out = alu_Bin - alu_Ain;
          2'b10:   alu_out = alu_Ain ^ alu_Bin;
          default: alu_out = alu_Ain & ~alu_Bin;
        endcase
      end
      5'b11010: begin
        case (alu_funct)
          2'b00:   alu_out = rol_v;
          2'b01:   alu_out = alu_Ain << sh;
          2'b10:   alu_out = ror_v;
          default: alu_out = alu_Ain >> sh;
        endcase
      end
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    logic [15:0] ins;
    logic        legal;
    logic        is_r;
    logic [2:0]  exp_rs;
    logic [2:0]  exp_rt;
    logic [4:0]  exp_op;
    logic [1:0]  exp_funct;
    logic [15:0] exp_ain;
    logic [15:0] exp_bin;
    logic [2:0]  exp_reg;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
  } wb_t;

  localparam int NV = 11;
  vec_t vecs [NV];
  wb_t  sbq [$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " alu_opcode"}, alu_opcode, 0);
    check({tag, " alu_funct"}, alu_funct, 0);
    check({tag, " alu_Ain"}, alu_Ain, 0);
    check({tag, " alu_Bin"}, alu_Bin, 0);
    check({tag, " wb_valid"}, wb_valid, 0);
    check({tag, " wb_reg"}, wb_reg, 0);
    check({tag, " wb_data"}, wb_data, 0);
    check({tag, " rs_addr"}, rs_addr, 0);
    check({tag, " rt_addr"}, rt_addr, 0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    check({tag, " illegal"}, illegal, 0);
    check({tag, " err_sticky"}, err_sticky, 0);
`endif
  endtask

  // Offers one instruction from IDLE; returns #1 after the accept edge (OPER cycle).
  task automatic applyStimulus(input vec_t v, input bit push);
    @(negedge clk);
    check("in_ready before accept", in_ready, 1);
    in_valid = 1'b1;
    instr    = v.ins;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instr    = 16'($urandom);
    if (push && v.legal) sbq.push_back('{rd: v.exp_reg, data: v.exp_data});
  endtask

  task automatic checkOutput();
    wb_t e;
    check("wb_valid at writeback", wb_valid, 1);
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: writeback 0x%0h with no expected entry", wb_data);
    end else begin
      e = sbq.pop_front();
      check("wb_reg", wb_reg, e.rd);
      check("wb_data", wb_data, e.data);
    end
  endtask

  // Steps edges until wb_valid; edges counts rising edges after the accept edge.
  task automatic waitWb(output int edges);
    edges = 1;
    while (!wb_valid && edges < 8) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic runVector(input vec_t v);
    int n;
    applyStimulus(v, 1'b1);
    check("in_ready busy in OPER", in_ready, 0);
    if (v.legal) begin
      check("rs_addr", rs_addr, v.exp_rs);
      if (v.is_r) check("rt_addr", rt_addr, v.exp_rt);
      @(posedge clk);
      #1;
      check("alu_opcode", alu_opcode, v.exp_op);
      check("alu_funct", alu_funct, v.exp_funct);
      check("alu_Ain", alu_Ain, v.exp_ain);
      check("alu_Bin", alu_Bin, v.exp_bin);
      check("wb_valid low in EXEC", wb_valid, 0);
      waitWb(n);
      check("wb latency edges", 16'(n), 2);
      checkOutput();
      @(posedge clk);
      #1;
      check("wb_valid after handshake", wb_valid, 0);
      check("in_ready after handshake", in_ready, 1);
      check("alu_Ain held after EXEC", alu_Ain, v.exp_ain);
    end else begin
`ifdef ALU_ISSUE_ILLEGAL_EN
      check("illegal pulse", illegal, 1);
      check("err_sticky set", err_sticky, 1);
`endif
      @(posedge clk);
      #1;
      check("in_ready back after illegal", in_ready, 1);
`ifdef ALU_ISSUE_ILLEGAL_EN
      check("illegal one cycle", illegal, 0);
      check("err_sticky holds", err_sticky, 1);
`endif
      n = 0;
      repeat (4) begin
        @(posedge clk);
        #1;
        if (wb_valid) n++;
      end
      check("no writeback for illegal", 16'(n), 0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    wb_t e;
    regs = '{16'h0000, 16'h0002, 16'h0003, 16'h8001, 16'h00F0, 16'h1234, 16'hFFFF, 16'h0F0F};
    //        ins       legal is_r  rs    rt    op        funct  ain       bin       rd    data
    vecs[0]  = '{16'h4165, 1'b1, 1'b0, 3'd1, 3'd3, 5'b01000, 2'b00, 16'h0002, 16'h0005, 3'd3, 16'h0007};
    vecs[1]  = '{16'h495F, 1'b1, 1'b0, 3'd1, 3'd2, 5'b01001, 2'b00, 16'h0002, 16'hFFFF, 3'd2, 16'hFFFD};
    vecs[2]  = '{16'h515F, 1'b1, 1'b0, 3'd1, 3'd2, 5'b01010, 2'b00, 16'h0002, 16'h001F, 3'd2, 16'h001D};
    vecs[3]  = '{16'hD950, 1'b1, 1'b1, 3'd1, 3'd2, 5'b11011, 2'b00, 16'h0002, 16'h0003, 3'd4, 16'h0005};
    vecs[4]  = '{16'h0800, 1'b0, 1'b0, 3'd0, 3'd0, 5'b00000, 2'b00, 16'h0000, 16'h0000, 3'd0, 16'h0000};
    vecs[5]  = '{16'h5DEF, 1'b1, 1'b0, 3'd5, 3'd7, 5'b01011, 2'b00, 16'h1234, 16'h000F, 3'd7, 16'h1230};
    vecs[6]  = '{16'hAC33, 1'b1, 1'b0, 3'd4, 3'd1, 5'b10101, 2'b00, 16'h00F0, 16'h0003, 3'd1, 16'h0780};
    vecs[7]  = '{16'hB3C1, 1'b1, 1'b0, 3'd3, 3'd6, 5'b10110, 2'b00, 16'h8001, 16'h0001, 3'd6, 16'hC000};
    vecs[8]  = '{16'hD657, 1'b1, 1'b1, 3'd6, 3'd2, 5'b11010, 2'b11, 16'hFFFF, 16'h0003, 3'd5, 16'h1FFF};
    vecs[9]  = '{16'hD981, 1'b1, 1'b1, 3'd1, 3'd4, 5'b11011, 2'b01, 16'h0002, 16'h00F0, 3'd0, 16'h00EE};
    vecs[10] = '{16'hF800, 1'b0, 1'b0, 3'd0, 3'd0, 5'b00000, 2'b00, 16'h0000, 16'h0000, 3'd0, 16'h0000};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    instr    = '0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready after reset", in_ready, 1);

    for (int i = 0; i < NV; i++) runVector(vecs[i]);

    // Backpressure: stall 3 cycles in WB while a second instruction is already offered.
    wb_ready = 1'b0;
    applyStimulus(vecs[0], 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    instr    = vecs[2].ins;
    repeat (3) begin
      check("stall wb_valid", wb_valid, 1);
      check("stall wb_reg", wb_reg, 3);
      check("stall wb_data", wb_data, 16'h0007);
      check("stall in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    checkOutput();
    @(negedge clk);
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    check("handshake wb_valid", wb_valid, 0);
    check("second not accepted in WB", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sbq.push_back('{rd: vecs[2].exp_reg, data: vecs[2].exp_data});
    check("second accepted after handshake", in_ready, 0);
    @(posedge clk);
    #1;
    check("second alu_Bin", alu_Bin, vecs[2].exp_bin);
    waitWb(n);
    check("second wb latency", 16'(n), 2);
    checkOutput();
    @(posedge clk);
    #1;

    // Reset during EXEC aborts the instruction.
`ifdef ALU_ISSUE_ILLEGAL_EN
    check("err_sticky persists", err_sticky, 1);
`endif
    applyStimulus(vecs[0], 1'b0);
    @(posedge clk);
    #1;
    check("alu_Ain before abort", alu_Ain, 16'h0002);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("reset in EXEC");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (wb_valid) n++;
    end
    check("no writeback after abort", 16'(n), 0);
    check("in_ready after abort", in_ready, 1);
    runVector(vecs[0]);

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: %0d entries left", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
